// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall/flush controller for a 5-stage RV32I pipeline, sitting beside ID.
// Tracks in-flight destinations and produces the registered EX forwarding selects.
module pipe_hazard_ctrl #(
    parameter bit FWD_EN = 1'b1,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [6:0]       id_opcode,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_rd,
    input  logic             ex_redirect,
    input  logic             mem_busy,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic [1:0]       ex_fwd_a,
    output logic [1:0]       ex_fwd_b,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam logic [6:0] OP_LOAD = 7'b0000011;

    // The WB slot would only ever feed decisions that are already made one
    // cycle earlier from MEM (fwd = 2) or are excluded by write-first regfile,
    // so only EX and MEM destinations are stored.
    logic       ex_v,  mem_v;
    logic [4:0] ex_rd, mem_rd;
    logic       ex_ld;

    logic ex_wr, mem_wr;
    logic rs1_ex, rs2_ex, rs1_mem, rs2_mem;
    logic haz;

    assign ex_wr  = ex_v  && (ex_rd  != 5'd0);
    assign mem_wr = mem_v && (mem_rd != 5'd0);

    assign rs1_ex  = ex_wr  && (id_rs1 != 5'd0) && (ex_rd  == id_rs1);
    assign rs2_ex  = ex_wr  && (id_rs2 != 5'd0) && (ex_rd  == id_rs2);
    assign rs1_mem = mem_wr && (id_rs1 != 5'd0) && (mem_rd == id_rs1);
    assign rs2_mem = mem_wr && (id_rs2 != 5'd0) && (mem_rd == id_rs2);

    always_comb begin
        haz = 1'b0;
        if (FWD_EN)
            haz = id_valid && ex_ld && (rs1_ex || rs2_ex);
        else
            haz = id_valid && (rs1_ex || rs2_ex || rs1_mem || rs2_mem);
    end

    always_comb begin
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        if (!rst_n) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end else if (mem_busy) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
        end else if (ex_redirect) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end else if (haz) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_bubble = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_v         <= 1'b0;
            ex_rd        <= 5'd0;
            ex_ld        <= 1'b0;
            mem_v        <= 1'b0;
            mem_rd       <= 5'd0;
            ex_fwd_a     <= 2'd0;
            ex_fwd_b     <= 2'd0;
            stall_cycles <= '0;
        end else if (!mem_busy) begin
            mem_v  <= ex_v;
            mem_rd <= ex_rd;
            ex_v   <= id_valid && !id_ex_bubble;
            ex_rd  <= id_rd;
            ex_ld  <= (id_opcode == OP_LOAD);

            // Nearest producer wins: the instruction leaving EX beats the one leaving MEM.
            if (!FWD_EN || id_ex_bubble) begin
                ex_fwd_a <= 2'd0;
                ex_fwd_b <= 2'd0;
            end else begin
                ex_fwd_a <= rs1_ex ? 2'd1 : (rs1_mem ? 2'd2 : 2'd0);
                ex_fwd_b <= rs2_ex ? 2'd1 : (rs2_mem ? 2'd2 : 2'd0);
            end

            if (!ex_redirect && haz && (stall_cycles != {CNT_W{1'b1}}))
                stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: the driver queues hand-computed expectations
// per cycle, a negedge monitor pops and compares them against the selected DUT.
module tb_pipe_hazard_ctrl;

    localparam logic [6:0] LD  = 7'b0000011;
    localparam logic [6:0] ALU = 7'b0110011;
    localparam logic [6:0] IMM = 7'b0010011;

    localparam logic [3:0] RUN = 4'b1100;
    localparam logic [3:0] STL = 4'b0001;
    localparam logic [3:0] FRZ = 4'b0000;
    localparam logic [3:0] RDR = 4'b1111;
    localparam logic [3:0] RST = 4'b0011;

    localparam logic [3:0] M_E  = 4'b0001;
    localparam logic [3:0] M_EC = 4'b1001;
    localparam logic [3:0] M_AL = 4'b1111;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       id_valid = 1'b0;
    logic [6:0] id_opcode = 7'd0;
    logic [4:0] id_rs1 = 5'd0, id_rs2 = 5'd0, id_rd = 5'd0;
    logic       ex_redirect = 1'b0;
    logic       mem_busy = 1'b0;

    logic        f1_pc_en, f1_if_id_en, f1_if_id_flush, f1_id_ex_bubble;
    logic [1:0]  f1_fwd_a, f1_fwd_b;
    logic [15:0] f1_stall;
    logic        f0_pc_en, f0_if_id_en, f0_if_id_flush, f0_id_ex_bubble;
    logic [1:0]  f0_fwd_a, f0_fwd_b;
    logic [1:0]  f0_stall;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.FWD_EN(1'b1), .CNT_W(16)) dut_fwd (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .ex_redirect(ex_redirect), .mem_busy(mem_busy),
        .pc_en(f1_pc_en), .if_id_en(f1_if_id_en), .if_id_flush(f1_if_id_flush),
        .id_ex_bubble(f1_id_ex_bubble), .ex_fwd_a(f1_fwd_a), .ex_fwd_b(f1_fwd_b),
        .stall_cycles(f1_stall)
    );

    pipe_hazard_ctrl #(.FWD_EN(1'b0), .CNT_W(2)) dut_nofwd (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .ex_redirect(ex_redirect), .mem_busy(mem_busy),
        .pc_en(f0_pc_en), .if_id_en(f0_if_id_en), .if_id_flush(f0_if_id_flush),
        .id_ex_bubble(f0_id_ex_bubble), .ex_fwd_a(f0_fwd_a), .ex_fwd_b(f0_fwd_b),
        .stall_cycles(f0_stall)
    );

    typedef struct {
        bit          sel;
        logic [3:0]  mask;
        logic [3:0]  e;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic [15:0] cnt;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    // One row per cycle: inputs for this cycle, then the outputs expected during it.
    task automatic cyc(input logic rn, input logic busy, input logic redir,
                       input logic v, input logic [6:0] op, input logic [4:0] r1,
                       input logic [4:0] r2, input logic [4:0] rd,
                       input bit sel, input logic [3:0] mask, input logic [3:0] e,
                       input logic [1:0] fa, input logic [1:0] fb,
                       input logic [15:0] cnt, input string name);
        exp_t x;
        @(posedge clk);
        #1;
        rst_n = rn; mem_busy = busy; ex_redirect = redir;
        id_valid = v; id_opcode = op; id_rs1 = r1; id_rs2 = r2; id_rd = rd;
        x.sel = sel; x.mask = mask; x.e = e; x.fa = fa; x.fb = fb; x.cnt = cnt; x.name = name;
        sb.push_back(x);
    endtask

    exp_t        r;
    logic [3:0]  a_e;
    logic [1:0]  a_fa, a_fb;
    logic [15:0] a_cnt;

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            r = sb.pop_front();
            if (!r.sel) begin
                a_e   = {f1_pc_en, f1_if_id_en, f1_if_id_flush, f1_id_ex_bubble};
                a_fa  = f1_fwd_a;
                a_fb  = f1_fwd_b;
                a_cnt = f1_stall;
            end else begin
                a_e   = {f0_pc_en, f0_if_id_en, f0_if_id_flush, f0_id_ex_bubble};
                a_fa  = f0_fwd_a;
                a_fb  = f0_fwd_b;
                a_cnt = {14'd0, f0_stall};
            end
            if (r.mask[0]) begin
                n_chk++;
                if (a_e !== r.e) begin
                    n_fail++;
                    $display("FAIL %s enables{pc,ifid,flush,bubble}: got %b want %b", r.name, a_e, r.e);
                end
            end
            if (r.mask[1]) begin
                n_chk++;
                if (a_fa !== r.fa) begin
                    n_fail++;
                    $display("FAIL %s ex_fwd_a: got %0d want %0d", r.name, a_fa, r.fa);
                end
            end
            if (r.mask[2]) begin
                n_chk++;
                if (a_fb !== r.fb) begin
                    n_fail++;
                    $display("FAIL %s ex_fwd_b: got %0d want %0d", r.name, a_fb, r.fb);
                end
            end
            if (r.mask[3]) begin
                n_chk++;
                if (a_cnt !== r.cnt) begin
                    n_fail++;
                    $display("FAIL %s stall_cycles: got %0d want %0d", r.name, a_cnt, r.cnt);
                end
            end
        end
    end

    initial begin
        // rn bsy rdr  v  op   rs1 rs2 rd   sel mask  en   fa fb cnt
        cyc(0, 0, 0, 1, ALU, 1, 2, 3,   0, M_E,  RST, 0, 0, 0, "rst0");
        cyc(0, 0, 0, 1, ALU, 1, 2, 3,   0, M_AL, RST, 0, 0, 0, "rst1");
        cyc(0, 0, 0, 1, ALU, 1, 2, 3,   0, M_AL, RST, 0, 0, 0, "rst2");
        cyc(1, 0, 0, 0, 0,   0, 0, 0,   0, M_AL, RUN, 0, 0, 0, "post_rst");

        // load-use: lw x5 ; add x6,x5,x7
        cyc(1, 0, 0, 1, LD,  1, 0, 5,   0, M_AL, RUN, 0, 0, 0, "lu_lw");
        cyc(1, 0, 0, 1, ALU, 5, 7, 6,   0, M_AL, STL, 0, 0, 0, "lu_stall");
        cyc(1, 0, 0, 1, ALU, 5, 7, 6,   0, M_AL, RUN, 0, 0, 1, "lu_issue");
        cyc(1, 0, 0, 0, 0,   0, 0, 0,   0, M_AL, RUN, 2, 0, 1, "lu_fwd");

        // ALU forwarding: addi x3 ; sub x4,x3,x3 ; nop ; add x9,x4,x0 ; addi x0,x9
        cyc(1, 0, 0, 1, IMM, 0, 0, 3,   0, M_AL, RUN, 0, 0, 1, "alu_addi");
        cyc(1, 0, 0, 1, ALU, 3, 3, 4,   0, M_AL, RUN, 0, 0, 1, "alu_sub");
        cyc(1, 0, 0, 0, 0,   0, 0, 0,   0, M_AL, RUN, 1, 1, 1, "alu_fwd1");
        cyc(1, 0, 0, 1, ALU, 4, 0, 9,   0, M_AL, RUN, 0, 0, 1, "gap_add");
        cyc(1, 0, 0, 1, IMM, 9, 0, 0,   0, M_AL, RUN, 2, 0, 1, "gap_fwd2");
        cyc(1, 0, 0, 1, ALU, 0, 0, 11,  0, M_AL, RUN, 1, 0, 1, "x0dst_prod");
        cyc(1, 0, 0, 1, LD,  2, 0, 0,   0, M_AL, RUN, 0, 0, 1, "x0dst_fwd0");
        cyc(1, 0, 0, 1, ALU, 0, 0, 12,  0, M_AL, RUN, 0, 0, 1, "x0_load_nohaz");

        // redirect coincident with load-use
        cyc(1, 0, 0, 1, LD,  1, 0, 5,   0, M_AL, RUN, 0, 0, 1, "rd_lw");
        cyc(1, 0, 1, 1, ALU, 5, 7, 6,   0, M_AL, RDR, 0, 0, 1, "rd_vs_haz");
        cyc(1, 0, 0, 0, 0,   0, 0, 0,   0, M_AL, RUN, 0, 0, 1, "rd_after");

        // freeze during load-use stall
        cyc(1, 0, 0, 1, LD,  1, 0, 5,   0, M_EC, RUN, 0, 0, 1, "fz_lw");
        cyc(1, 1, 0, 1, ALU, 5, 7, 6,   0, M_EC, FRZ, 0, 0, 1, "fz0");
        cyc(1, 1, 1, 1, ALU, 5, 7, 6,   0, M_EC, FRZ, 0, 0, 1, "fz1_redir");
        cyc(1, 1, 0, 1, ALU, 5, 7, 6,   0, M_EC, FRZ, 0, 0, 1, "fz2");
        cyc(1, 1, 0, 1, ALU, 5, 7, 6,   0, M_EC, FRZ, 0, 0, 1, "fz3");
        cyc(1, 0, 0, 1, ALU, 5, 7, 6,   0, M_AL, STL, 0, 0, 1, "fz_release_stall");
        cyc(1, 0, 0, 1, ALU, 5, 7, 6,   0, M_AL, RUN, 0, 0, 2, "fz_issue");
        cyc(1, 0, 0, 0, 0,   0, 0, 0,   0, M_AL, RUN, 2, 0, 2, "fz_fwd");

        // no-forwarding instance, 2-bit counter: addi x1 ; add x2,x1,x1 ; add x3,x2,x2 ; add x4,x3,x3
        cyc(0, 0, 0, 0, 0,   0, 0, 0,   1, M_E,  RST, 0, 0, 0, "nf_rst");
        cyc(1, 0, 0, 1, IMM, 0, 0, 1,   1, M_AL, RUN, 0, 0, 0, "nf_addi");
        cyc(1, 0, 0, 1, ALU, 1, 1, 2,   1, M_AL, STL, 0, 0, 0, "nf_a_s1");
        cyc(1, 0, 0, 1, ALU, 1, 1, 2,   1, M_AL, STL, 0, 0, 1, "nf_a_s2");
        cyc(1, 0, 0, 1, ALU, 1, 1, 2,   1, M_AL, RUN, 0, 0, 2, "nf_a_go");
        cyc(1, 0, 0, 1, ALU, 2, 2, 3,   1, M_AL, STL, 0, 0, 2, "nf_b_s1");
        cyc(1, 0, 0, 1, ALU, 2, 2, 3,   1, M_AL, STL, 0, 0, 3, "nf_b_s2");
        cyc(1, 0, 0, 1, ALU, 2, 2, 3,   1, M_AL, RUN, 0, 0, 3, "nf_b_go");
        cyc(1, 0, 0, 1, ALU, 3, 3, 4,   1, M_AL, STL, 0, 0, 3, "nf_c_s1");
        cyc(1, 0, 0, 1, ALU, 3, 3, 4,   1, M_AL, STL, 0, 0, 3, "nf_c_s2_sat");
        cyc(1, 0, 0, 1, ALU, 3, 3, 4,   1, M_AL, RUN, 0, 0, 3, "nf_c_go");
        cyc(1, 0, 0, 0, 0,   0, 0, 0,   1, M_AL, RUN, 0, 0, 3, "nf_end");

        repeat (2) @(posedge clk);
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, want 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Pipeline controller for the 5-stage RV32I core.
- Sits beside the ID stage and takes the decoded rs1/rs2/rd/opcode of the instruction in ID.
- Tracks destination registers in flight in the EX, MEM and WB stages.
- Drives the PC and IF/ID enables, the IF/ID flush and ID/EX bubble insertion, and the registered EX-stage forwarding selects.
- Also maintains a saturating hazard-stall counter.

Parameters:
- FWD_EN, 1: 1 = forward from MEM/WB and stall only on load-use; 0 = no forwarding, stall on any RAW against EX or MEM.
- CNT_W, 16: width of the stall-cycle counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- id_valid  in  1  ID stage holds a real instruction.
- id_opcode  in  7  decoded opcode of the ID instruction.
- id_rs1  in  5  source 1; 0 when the opcode does not read rs1.
- id_rs2  in  5  source 2; 0 when the opcode does not read rs2.
- id_rd  in  5  destination; 0 for branch and store.
- ex_redirect  in  1  EX resolved a taken branch, JAL or JALR.
- mem_busy  in  1  data memory not ready; the whole pipeline freezes.
- pc_en  out  1  PC register update enable.
- if_id_en  out  1  IF/ID register load enable.
- if_id_flush  out  1  load a NOP into IF/ID.
- id_ex_bubble  out  1  load a NOP into ID/EX instead of the ID instruction.
- ex_fwd_a  out  2  rs1 operand select for the instruction in EX: 0 regfile, 1 MEM result, 2 WB result.
- ex_fwd_b  out  2  rs2 operand select, same encoding.
- stall_cycles  out  CNT_W  saturating count of hazard stall cycles.

Behaviour:
- Slot state: EX, MEM and WB slots, each holding {v, rd, ld}.
  - wr = v and rd != 0.
  - ld = (opcode == 7'b0000011).
  - A slot with rd = 0 never causes a hazard or a forward.
- Reset (rst_n low at an edge): all slots invalid, ex_fwd_a = ex_fwd_b = 0, stall_cycles = 0.
  - While rst_n is low, combinationally: pc_en = 0, if_id_en = 0, if_id_flush = 1, id_ex_bubble = 1.
- Hazard condition: haz = id_valid and match on a nonzero rs1 or rs2.
  - FWD_EN = 1: match against EX slot where wr and ld.
  - FWD_EN = 0: match against EX slot wr, or MEM slot wr.
  - Register writes in WB are write-first, so WB never causes a hazard.
- Priority, evaluated every cycle, combinational outputs:
  1. mem_busy = 1: pc_en = 0, if_id_en = 0, flush = 0, bubble = 0. Slots, ex_fwd and the counter hold. ex_redirect is ignored while mem_busy = 1; EX holds it until the freeze ends.
  2. ex_redirect = 1: pc_en = 1, if_id_en = 1, if_id_flush = 1, id_ex_bubble = 1. Takes precedence over haz; the counter does not increment.
  3. haz = 1: pc_en = 0, if_id_en = 0, flush = 0, id_ex_bubble = 1. stall_cycles increments, saturating at all-ones.
  4. Otherwise: pc_en = 1, if_id_en = 1, flush = 0, bubble = 0.
- Slot advance, on every edge with rst_n = 1 and mem_busy = 0:
  - WB <= MEM, MEM <= EX.
  - EX <= {id_valid and not id_ex_bubble, id_rd, ld(id_opcode)}.
- Forwarding, registered with the EX advance, FWD_EN = 1 only:
  - ex_fwd_a = 1 if the old EX slot (becoming MEM) is wr and rd == id_rs1 != 0.
  - Else 2 if the old MEM slot (becoming WB) is wr and matches.
  - Else 0.
  - ex_fwd_b is the same rule on id_rs2. The nearest producer wins.
  - On a bubble, the forwarding selects load 0.
  - With FWD_EN = 0 they are constant 0.
- Latency:
  - Load-use costs exactly 1 stall cycle; the consumer then issues with fwd = 2.
  - With FWD_EN = 0, a back-to-back RAW costs 2 stall cycles.

Test Plan:
- Reset: hold rst_n = 0 for 3 cycles with id_valid = 1 -> pc_en = 0, if_id_flush = 1, id_ex_bubble = 1. After release: pc_en = 1, ex_fwd_a = 0, stall_cycles = 0.
- Load-use: lw x5 in ID, then add x6, x5, x7 -> one cycle with pc_en = 0, id_ex_bubble = 1, stall_cycles = 1. The add then enters EX with ex_fwd_a = 2, ex_fwd_b = 0.
- ALU forwarding: addi x3, x0, 1 then sub x4, x3, x3 -> no stall; the sub reaches EX with ex_fwd_a = ex_fwd_b = 1. A one-gap distance gives 2. Using x0 as the destination gives 0.
- Redirect versus hazard: ex_redirect = 1 in the same cycle as a load-use hazard -> if_id_flush = 1, id_ex_bubble = 1, pc_en = 1, and stall_cycles unchanged.
- Freeze: mem_busy = 1 for 4 cycles during a load-use stall -> all enables 0 and slots unchanged. Exactly 1 hazard stall cycle follows the release, and the count increments by 1 only.
- FWD_EN = 0, CNT_W = 2: a chain of 3 back-to-back dependent ALU ops -> 2 stall cycles each, and stall_cycles saturates at 3.
